imem_program_loader: RTL and testbench

//  Writer side of the 12-bit instruction memory that the single-cycle MIPS core fetches IR from.

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/loader_csum_acc.sv | 30 +++
 rtl/imem_program_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_program_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the imem program loader: FSM state encoding,
// error codes and the fixed instruction/stream widths.
package imem_loader_pkg;

   localparam int INSTR_W = 12;
   localparam int BYTE_W  = 8;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_COUNT = 2'b01;
   localparam logic [1:0] ERR_FMT   = 2'b10;
   localparam logic [1:0] ERR_CSUM  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CNT  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CSUM = 3'd4,
      ST_DONE = 3'd5,
      ST_ERR  = 3'd6
   } state_e;

endpackage

// File: rtl/loader_csum_acc.sv
// XOR accumulator for the frame checksum. Clear wins over load, load over enable.
module loader_csum_acc #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         enable,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   logic [W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clear)       acc_d = '0;
      else if (load)   acc_d = din;
      else if (enable) acc_d = acc_q ^ din;
   end

   always_ff @(posedge clock) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/imem_program_loader.sv
// Framed byte-stream loader for the 12-bit instruction memory; holds the core
// until a frame of N words has been written and its XOR checksum matches.
module imem_program_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [BYTE_W-1:0]  in_byte,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               load_done,
   output logic [1:0]         err_code,
   output state_e             state_dbg
);

   // Handshake: a byte moves on a clock edge where in_valid and in_ready are
   // both high; in_ready depends only on state, never on in_valid.
   localparam int DEPTH = 2 ** ADDR_W;

   state_e               state_q, state_d;
   logic [ADDR_W:0]      word_idx_q, word_idx_d;
   logic [ADDR_W:0]      cnt_q, cnt_d;
   logic [BYTE_W-1:0]    hi_q, hi_d;
   logic                 we_q, we_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [INSTR_W-1:0]   wdata_q, wdata_d;
   logic                 hold_q, hold_d;
   logic                 done_q, done_d;
   logic [1:0]           err_q, err_d;
   logic                 csum_clear, csum_load, csum_en;
   logic [BYTE_W-1:0]    csum;
   logic                 xfer;
   logic [ADDR_W:0]      word_next;

   loader_csum_acc #(.W(BYTE_W)) u_csum (
      .clock  (clock),
      .reset  (reset),
      .clear  (csum_clear),
      .load   (csum_load),
      .enable (csum_en),
      .din    (in_byte),
      .acc    (csum)
   );

   // Counter is one bit wider than the address so N == DEPTH compares cleanly.
   assign word_next = word_idx_q + (ADDR_W+1)'(1);
   assign xfer      = in_valid & in_ready;

   always_comb begin
      state_d    = state_q;
      word_idx_d = word_idx_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      hold_d     = hold_q;
      done_d     = done_q;
      err_d      = err_q;
      csum_clear = 1'b0;
      csum_load  = 1'b0;
      csum_en    = 1'b0;
      in_ready   = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d    = ST_CNT;
               hold_d     = 1'b1;
               done_d     = 1'b0;
               err_d      = ERR_NONE;
               csum_clear = 1'b1;
            end
         end
         ST_CNT: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (in_byte == '0 || int'(in_byte) > DEPTH) begin
                  state_d = ST_ERR;
                  err_d   = ERR_COUNT;
               end else begin
                  state_d    = ST_HI;
                  word_idx_d = '0;
                  cnt_d      = in_byte[ADDR_W:0];
                  csum_load  = 1'b1;
               end
            end
         end
         ST_HI: begin
            in_ready = 1'b1;
            if (xfer) begin
               state_d = ST_LO;
               hi_d    = in_byte;
               csum_en = 1'b1;
            end
         end
         ST_LO: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (in_byte[7:4] != 4'h0) begin
                  state_d = ST_ERR;
                  err_d   = ERR_FMT;
               end else begin
                  we_d       = 1'b1;
                  addr_d     = word_idx_q[ADDR_W-1:0];
                  wdata_d    = {hi_q, in_byte[3:0]};
                  word_idx_d = word_next;
                  csum_en    = 1'b1;
                  state_d    = (word_next < cnt_q) ? ST_HI : ST_CSUM;
               end
            end
         end
         ST_CSUM: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (in_byte == csum) begin
                  state_d = ST_DONE;
                  hold_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = ERR_CSUM;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         word_idx_q <= '0;
         cnt_q      <= '0;
         hi_q       <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         word_idx_q <= word_idx_d;
         cnt_q      <= cnt_d;
         hi_q       <= hi_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         hold_q     <= hold_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_hold   = hold_q;
   assign load_done  = done_q;
   assign err_code   = err_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: framed loads, stalls, error paths and
// reset mid-frame, with writes checked against an expected {addr,data} queue.
module tb_imem_program_loader;
   import imem_loader_pkg::*;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_byte = 8'h00;
   logic         in_ready;
   logic         imem_we;
   logic [3:0]   imem_addr;
   logic [11:0]  imem_wdata;
   logic         cpu_hold;
   logic         load_done;
   logic [1:0]   err_code;
   state_e       state_dbg;

   int           n_checks = 0;
   int           n_fail = 0;
   logic [15:0]  exp_q[$];
   logic [7:0]   frame_q[$];

   imem_program_loader #(.ADDR_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .err_code   (err_code),
      .state_dbg  (state_dbg)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Write scoreboard; an extra write is compared against a value it can never equal.
   always @(negedge clock) begin
      if (imem_we === 1'b1) begin
         if (exp_q.size() == 0) check("write_extra", {16'h0, imem_addr, imem_wdata}, 32'h0001_0000);
         else check("write", {16'h0, imem_addr, imem_wdata}, {16'h0, exp_q.pop_front()});
      end
   end

   task automatic send_byte(input logic [7:0] b, input int max_gap, input logic with_start);
      int gaps;
      gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gaps; g++) begin
         @(negedge clock);
         start    = 1'b0;
         in_valid = 1'b0;
         in_byte  = 8'($urandom);
      end
      @(negedge clock);
      start    = with_start;
      in_valid = 1'b1;
      in_byte  = b;
      check("ready", {31'h0, in_ready}, 32'h1);
      check("hold_mid", {31'h0, cpu_hold}, 32'h1);
      @(posedge clock);
   endtask

   task automatic send_frame(input int max_gap);
      foreach (frame_q[i]) send_byte(frame_q[i], max_gap, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      start    = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      in_valid = 1'b0;
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;
   endtask

   task automatic check_status(input string tag, input logic hold, input logic done, input logic [1:0] err);
      check({tag, "_hold"}, {31'h0, cpu_hold}, {31'h0, hold});
      check({tag, "_done"}, {31'h0, load_done}, {31'h0, done});
      check({tag, "_err"}, {30'h0, err_code}, {30'h0, err});
   endtask

   initial begin
      logic [7:0] cs;
      logic [7:0] hi;
      logic [3:0] lo;

      // Reset values
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_ready", {31'h0, in_ready}, 32'h0);
      check("rst_we", {31'h0, imem_we}, 32'h0);
      check("rst_addr", {28'h0, imem_addr}, 32'h0);
      check("rst_wdata", {20'h0, imem_wdata}, 32'h0);
      check_status("rst", 1'b1, 1'b0, ERR_NONE);
      check("rst_state", {29'h0, state_dbg}, {29'h0, ST_IDLE});
      reset = 1'b0;

      // 1: two words, valid always high; the XOR of 02,A5,03,1F,0C is B7
      exp_q = '{16'h0A53, 16'h11FC};
      frame_q = '{8'h02, 8'hA5, 8'h03, 8'h1F, 8'h0C, 8'hB7};
      pulse_start();
      send_frame(0);
      check_status("t1", 1'b0, 1'b1, ERR_NONE);
      check("t1_ready", {31'h0, in_ready}, 32'h0);

      // 2: same frame with idle gaps carrying garbage bytes
      exp_q = '{16'h0A53, 16'h11FC};
      pulse_start();
      check_status("t2_start", 1'b1, 1'b0, ERR_NONE);
      send_frame(3);
      check_status("t2", 1'b0, 1'b1, ERR_NONE);

      // 3: bad counts
      pulse_start();
      frame_q = '{8'h00};
      send_frame(0);
      check_status("t3a", 1'b1, 1'b0, ERR_COUNT);
      check("t3a_ready", {31'h0, in_ready}, 32'h0);
      pulse_start();
      frame_q = '{8'h11};
      send_frame(0);
      check_status("t3b", 1'b1, 1'b0, ERR_COUNT);
      check("t3b_ready", {31'h0, in_ready}, 32'h0);

      // 4: LO high nibble set, then recovery with a good frame
      pulse_start();
      frame_q = '{8'h01, 8'h7E, 8'h3A};
      send_frame(0);
      check_status("t4", 1'b1, 1'b0, ERR_FMT);
      pulse_start();
      check("t4_clear", {30'h0, err_code}, {30'h0, ERR_NONE});
      exp_q = '{16'h0124};
      frame_q = '{8'h01, 8'h12, 8'h04, 8'h17};
      send_frame(0);
      check_status("t4_ok", 1'b0, 1'b1, ERR_NONE);

      // 5: wrong checksum after a written word
      pulse_start();
      exp_q = '{16'h0124};
      frame_q = '{8'h01, 8'h12, 8'h04, 8'h00};
      send_frame(0);
      check_status("t5", 1'b1, 1'b0, ERR_CSUM);

      // 6: reset after three payload bytes, then a full 16-word frame
      pulse_start();
      exp_q = '{16'h0AB5};
      send_byte(8'h10, 0, 1'b0);
      send_byte(8'hAB, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'hCD, 0, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clock);
      check("t6_rst_ready", {31'h0, in_ready}, 32'h0);
      check("t6_rst_we", {31'h0, imem_we}, 32'h0);
      check("t6_rst_addr", {28'h0, imem_addr}, 32'h0);
      check("t6_rst_wdata", {20'h0, imem_wdata}, 32'h0);
      check_status("t6_rst", 1'b1, 1'b0, ERR_NONE);
      check("t6_rst_state", {29'h0, state_dbg}, {29'h0, ST_IDLE});
      reset = 1'b0;

      pulse_start();
      cs = 8'h10;
      send_byte(8'h10, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         hi = 8'(i * 17);
         lo = 4'(15 - i);
         cs = cs ^ hi ^ {4'h0, lo};
         exp_q.push_back({4'(i), hi, lo});
         send_byte(hi, 1, (i == 5));
         send_byte({4'h0, lo}, 1, (i == 10));
      end
      send_byte(cs, 0, 1'b0);
      @(negedge clock);
      in_valid = 1'b0;
      start    = 1'b0;
      check_status("t6", 1'b0, 1'b1, ERR_NONE);

      repeat (3) @(negedge clock);
      check("pending_writes", exp_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
